// File: rtl/xilly_demo.sv
// -----------------------------------------------------------------------------
// xilly_demo
//
// User-side streaming compute block for the Xillybus 32-bit pipes. Each
// 32-bit word written by the host carries two independent unsigned 16-bit
// samples (lane0 = [15:0], lane1 = [31:16]). Every lane is transformed as
// y = x*MUL + ADD through a 2-stage pipeline, and the results are queued in
// an output FIFO that the host drains through the 32-bit read stream.
//
// Build option:
//   XILLYDEMO_SAT_EN  defined     -> each lane saturates at 0xFFFF
//                     not defined -> each lane wraps (low 16 bits kept)
//   Timing and latency are identical in both builds.
//
// Parameters:
//   MUL    per-lane 16-bit unsigned multiplier (default 2)
//   ADD    per-lane 16-bit unsigned addend     (default 1)
//   DEPTH  output FIFO depth in words, power of two, >= 8 (default 1024)
//
// Ports:
//   bus_clk               in   sole clock, rising edge
//   bus_rst_n             in   asynchronous active-low reset
//   quiesce               in   core down; synchronous flush while high
//   user_w_write_32_wren  in   host write strobe
//   user_w_write_32_data  in   write word
//   user_w_write_32_full  out  write back-pressure (combinational)
//   user_w_write_32_open  in   write pipe open
//   user_r_read_32_rden   in   host read strobe
//   user_r_read_32_data   out  registered read word
//   user_r_read_32_empty  out  output FIFO empty
//   user_r_read_32_open   in   read pipe open
// -----------------------------------------------------------------------------
module xilly_demo #(
    parameter int unsigned MUL   = 2,
    parameter int unsigned ADD   = 1,
    parameter int unsigned DEPTH = 1024
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic        quiesce,
    input  logic        user_w_write_32_wren,
    input  logic [31:0] user_w_write_32_data,
    output logic        user_w_write_32_full,
    input  logic        user_w_write_32_open,
    input  logic        user_r_read_32_rden,
    output logic [31:0] user_r_read_32_data,
    output logic        user_r_read_32_empty,
    input  logic        user_r_read_32_open
);

    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam logic [15:0]   MUL16   = 16'(MUL);
    localparam logic [15:0]   ADD16   = 16'(ADD);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    // Product width held in stage 1. The wrapping build only ever keeps the
    // low 16 bits of x*MUL + ADD, and the upper product bits cannot influence
    // those, so only 16 bits of product are carried there.
`ifdef XILLYDEMO_SAT_EN
    localparam int unsigned PW = 32;
`else
    localparam int unsigned PW = 16;
`endif

    // -------------------------------------------------------------------------
    // Lane arithmetic
    // -------------------------------------------------------------------------
    function automatic logic [PW-1:0] lane_mul(input logic [15:0] x);
        return PW'(x) * PW'(MUL16);
    endfunction

    function automatic logic [15:0] lane_add(input logic [PW-1:0] p);
`ifdef XILLYDEMO_SAT_EN
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(ADD16);
        return (s[PW:16] != '0) ? 16'hFFFF : s[15:0];
`else
        return p + ADD16;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    logic          flush;
    logic          accept;
    logic          pop;
    logic          s1_valid;
    logic          s2_valid;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   fill;
    logic [AW+1:0] occupancy;

    assign flush = quiesce | (~user_w_write_32_open & ~user_r_read_32_open);

    // Pointers carry one extra wrap bit, so equal pointers mean empty and the
    // difference is the stored word count even across wrap-around.
    assign fill      = wr_ptr - rd_ptr;
    assign occupancy = {1'b0, fill} + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);

    // Words still in the pipeline are counted as already stored, which
    // reserves a FIFO slot for each of them before it is accepted.
    assign user_w_write_32_full = (occupancy >= DEPTH_W);
    assign user_r_read_32_empty = (wr_ptr == rd_ptr);

    assign accept = user_w_write_32_wren & ~user_w_write_32_full & ~flush;
    assign pop    = user_r_read_32_rden & ~user_r_read_32_empty & ~flush;

    // -------------------------------------------------------------------------
    // Pipeline
    // -------------------------------------------------------------------------
    logic [PW-1:0] p0_q;
    logic [PW-1:0] p1_q;
    logic [15:0]   r0_q;
    logic [15:0]   r1_q;

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
        end
    end

    // Data path registers need no reset: they are only consumed when the
    // matching valid bit is set.
    always_ff @(posedge bus_clk) begin
        if (accept) begin
            p0_q <= lane_mul(user_w_write_32_data[15:0]);
            p1_q <= lane_mul(user_w_write_32_data[31:16]);
        end
        if (s1_valid) begin
            r0_q <= lane_add(p0_q);
            r1_q <= lane_add(p1_q);
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO
    // -------------------------------------------------------------------------
    logic [31:0] mem [DEPTH];

    always_ff @(posedge bus_clk) begin
        if (s2_valid && !flush) begin
            mem[wr_ptr[AW-1:0]] <= {r1_q, r0_q};
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            user_r_read_32_data <= '0;
        end else if (flush) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            user_r_read_32_data <= '0;
        end else begin
            if (s2_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr              <= rd_ptr + 1'b1;
                user_r_read_32_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_xilly_demo.sv
module tb_xilly_demo;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned MUL   = 2;
    localparam int unsigned ADD   = 1;

`ifdef XILLYDEMO_SAT_EN
    localparam logic [31:0] ARITH_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] ARITH_EXP = 32'h0001_FFFF;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        quiesce = 1'b1;
    logic        wren    = 1'b0;
    logic [31:0] wdata   = '0;
    logic        wopen   = 1'b0;
    logic        rden    = 1'b0;
    logic        ropen   = 1'b0;
    logic        full;
    logic        empty;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    xilly_demo #(
        .MUL   (MUL),
        .ADD   (ADD),
        .DEPTH (DEPTH)
    ) dut (
        .bus_clk              (clk),
        .bus_rst_n            (rst_n),
        .quiesce              (quiesce),
        .user_w_write_32_wren (wren),
        .user_w_write_32_data (wdata),
        .user_w_write_32_full (full),
        .user_w_write_32_open (wopen),
        .user_r_read_32_rden  (rden),
        .user_r_read_32_data  (rdata),
        .user_r_read_32_empty (empty),
        .user_r_read_32_open  (ropen)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard: expected FIFO contents plus the two in-flight stages.
    logic [31:0] mq[$];
    bit          m_v1 = 1'b0;
    bit          m_v2 = 1'b0;
    logic [31:0] m_d1 = '0;
    logic [31:0] m_d2 = '0;
    logic [31:0] m_data = '0;

    function automatic logic [31:0] expect_word(input logic [31:0] x);
        logic [15:0]     y [2];
        longint unsigned s;
        for (int l = 0; l < 2; l++) begin
            s = 64'(x[16*l +: 16]) * 64'(MUL) + 64'(ADD);
`ifdef XILLYDEMO_SAT_EN
            y[l] = (s > 64'hFFFF) ? 16'hFFFF : s[15:0];
`else
            y[l] = s[15:0];
`endif
        end
        return {y[1], y[0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_v1   = 1'b0;
        m_v2   = 1'b0;
        m_data = '0;
    endtask

    // One clock edge: advance the scoreboard with the pre-edge inputs, then
    // compare all outputs 1 time unit after the edge.
    task automatic step(input string tag);
        bit fl;
        bit m_full;
        bit acc;
        bit pp;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            fl     = quiesce || (!wopen && !ropen);
            m_full = (mq.size() + int'(m_v1) + int'(m_v2)) >= int'(DEPTH);
            acc    = wren && !m_full && !fl;
            pp     = rden && (mq.size() != 0) && !fl;
            if (fl) begin
                model_clear();
            end else begin
                if (pp) m_data = mq.pop_front();
                if (m_v2) mq.push_back(m_d2);
                m_v2 = m_v1;
                m_d2 = m_d1;
                m_v1 = acc;
                m_d1 = expect_word(wdata);
            end
        end
        #1;
        check({tag, " empty"}, 32'(empty), 32'(mq.size() == 0));
        check({tag, " full"}, 32'(full),
              32'((mq.size() + int'(m_v1) + int'(m_v2)) >= int'(DEPTH)));
        check({tag, " data"}, rdata, m_data);
    endtask

    initial begin
        int full_seen;
        int dut_pops;

        // ---------------- reset then idle ----------------
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        check("reset empty", 32'(empty), 32'd1);
        check("reset full", 32'(full), 32'd0);
        check("reset data", rdata, 32'd0);
        step("in reset");
        step("in reset");
        rst_n = 1'b1;
        repeat (3) step("quiesce");
        quiesce = 1'b0;
        wopen   = 1'b1;
        ropen   = 1'b1;
        repeat (3) step("idle");
        check("idle empty", 32'(empty), 32'd1);
        check("idle data", rdata, 32'd0);

        // ---------------- single word latency ----------------
        rden  = 1'b1;
        wren  = 1'b1;
        wdata = 32'h0001_0000;
        step("single N");
        wren = 1'b0;
        step("single N+1");
        check("single empty before N+2", 32'(empty), 32'd1);
        step("single N+2");
        check("single empty in N+3", 32'(empty), 32'd0);
        step("single N+3");
        check("single data", rdata, 32'h0003_0001);
        check("single empty after pop", 32'(empty), 32'd1);

        // ---------------- streaming ----------------
        full_seen = 0;
        for (int k = 0; k < 1024; k++) begin
            wren  = 1'b1;
            wdata = {16'(2*k + 1), 16'(2*k)};
            step("stream");
            if (full) full_seen++;
        end
        wren = 1'b0;
        repeat (4) step("stream drain");
        check("stream full never", 32'(full_seen), 32'd0);
        check("stream last word", rdata, 32'h0FFF_0FFD);
        check("stream empty at end", 32'(empty), 32'd1);

        // ---------------- overflow ----------------
        rden = 1'b0;
        for (int i = 0; i < int'(DEPTH) + 5; i++) begin
            wren  = 1'b1;
            wdata = {16'(i*3), 16'(i)};
            step("ovf fill");
        end
        wren = 1'b0;
        repeat (3) step("ovf hold");
        check("ovf full held", 32'(full), 32'd1);
        rden     = 1'b1;
        dut_pops = 0;
        for (int i = 0; i < int'(DEPTH) + 5; i++) begin
            if (!empty) dut_pops++;
            step("ovf drain");
        end
        check("ovf words read", 32'(dut_pops), 32'(DEPTH));
        check("ovf last word", rdata, 32'h17FB_07FF);
        check("ovf empty at end", 32'(empty), 32'd1);
        check("ovf full released", 32'(full), 32'd0);

        // ---------------- arithmetic edge ----------------
        wren  = 1'b1;
        wdata = 32'h8000_7FFF;
        step("arith");
        wren = 1'b0;
        repeat (5) step("arith");
        check("arith result", rdata, ARITH_EXP);

        // ---------------- close / flush ----------------
        rden = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wren  = 1'b1;
            wdata = 32'(i);
            step("queue");
        end
        wren = 1'b0;
        repeat (2) step("queue");
        check("queued not empty", 32'(empty), 32'd0);
        wopen = 1'b0;
        ropen = 1'b0;
        step("closed");
        check("close empty", 32'(empty), 32'd1);
        check("close data", rdata, 32'd0);
        wopen = 1'b1;
        ropen = 1'b1;
        rden  = 1'b1;
        wren  = 1'b1;
        wdata = 32'h0000_0000;
        step("reopen");
        wren = 1'b0;
        repeat (4) step("reopen");
        check("reopen data", rdata, 32'h0001_0001);

        // ---------------- reset mid-stream ----------------
        rden = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wren  = 1'b1;
            wdata = 32'(i + 100);
            step("pre-reset");
        end
        wren = 1'b0;
        step("pre-reset");
        rst_n = 1'b0;
        #1;
        model_clear();
        check("async reset empty", 32'(empty), 32'd1);
        check("async reset full", 32'(full), 32'd0);
        check("async reset data", rdata, 32'd0);
        step("held reset");
        rst_n = 1'b1;
        step("post-reset");
        rden  = 1'b1;
        wren  = 1'b1;
        wdata = 32'h0005_0004;
        step("post-reset");
        wren = 1'b0;
        repeat (4) step("post-reset");
        check("post-reset data", rdata, 32'h000B_0009);
        check("post-reset empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
